// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/halt/step control blocks.
package cpu_ctrl_pkg;

  // Sequencer state encoding, also driven out on the STATE debug port.
  typedef logic [1:0] state_t;

  localparam logic [1:0] S_RESET = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_HALT  = 2'b10;
  localparam logic [1:0] S_STEP  = 2'b11;

  // Board defaults at 100 MHz: 1 Hz free-run, 10 ms debounce window.
  localparam int DEF_CLK_DIV   = 100_000_000;
  localparam int DEF_DB_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted 0->1 change of the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic edge_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          edge_q, edge_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level only after DB_CYCLES consecutive differing samples;
  // any sample that agrees with the current level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    edge_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        edge_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, counter and pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      edge_q  <= edge_d;
      cnt_q   <= cnt_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer: produces a one-cycle CPU clock enable,
// stretches the CPU reset, and keeps a heartbeat and executed-cycle count.
// Handshake note: CPU_CE is a plain strobe with no ready; each high cycle
// is exactly one CPU cycle and is never adjacent to another high cycle.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int RST_HOLD  = 16,
  parameter int CNT_W     = 16
) (
  input  logic             SYS_CLK,
  input  logic             RST,
  input  logic             HALT,
  input  logic             STEP,
  output logic             CPU_CE,
  output logic             CPU_RST,
  output logic             HB,
  output logic [CNT_W-1:0] CYC_CNT,
  output logic [1:0]       STATE
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic              halt_m_q, halt_s_q;
  logic              step_edge;
  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ce_q, ce_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              hb_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_db (
    .clk_i  (SYS_CLK),
    .rst_i  (RST),
    .btn_i  (STEP),
    .edge_o (step_edge)
  );

  // Next-state logic; CE is registered so it lines up with the state it belongs to.
  // The divider sits at 0 outside S_RUN so each run entry starts a full period.
  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    hold_d    = hold_q;
    ce_d      = 1'b0;
    cpu_rst_d = 1'b0;
    case (state_q)
      S_RESET: begin
        cpu_rst_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          cpu_rst_d = 1'b0;
          state_d   = halt_s_q ? S_HALT : S_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        // Halt has priority over a wrap in the same cycle; steps are ignored here.
        if (halt_s_q) begin
          state_d = S_HALT;
        end else if (div_q == DIV_LAST) begin
          ce_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HALT: begin
        // Leaving halt discards a step arriving in the same cycle.
        if (!halt_s_q) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          state_d = S_STEP;
          ce_d    = 1'b1;
        end
      end
      S_STEP:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Saturating count of CE pulses, advancing with the pulse itself.
  always_comb begin
    cnt_d = cnt_q;
    if (ce_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // State, counters and registered outputs; RST aborts any pulse on the same edge.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      halt_m_q  <= 1'b0;
      halt_s_q  <= 1'b0;
      state_q   <= S_RESET;
      div_q     <= '0;
      hold_q    <= '0;
      ce_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      hb_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      halt_m_q  <= HALT;
      halt_s_q  <= halt_m_q;
      state_q   <= state_d;
      div_q     <= div_d;
      hold_q    <= hold_d;
      ce_q      <= ce_d;
      cpu_rst_q <= cpu_rst_d;
      hb_q      <= hb_q ^ ce_q;
      cnt_q     <= cnt_d;
    end
  end

  assign CPU_CE  = ce_q;
  assign CPU_RST = cpu_rst_q;
  assign HB      = hb_q;
  assign CYC_CNT = cnt_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with small timing parameters.
module tb_cpu_run_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, halt, step;
  logic             cpu_ce, cpu_rst, hb;
  logic [CNT_W-1:0] cyc_cnt;
  logic [1:0]       state;

  int n_total = 0;
  int n_pass  = 0;

  // Monitor counters
  int ce_count    = 0;
  int step_cycles = 0;
  int viol_both   = 0;
  int viol_width  = 0;
  logic ce_prev   = 1'b0;

  int ce_base;
  int st_base;
  bit found;

  cpu_run_ctrl #(
    .CLK_DIV   (4),
    .DB_CYCLES (3),
    .RST_HOLD  (2),
    .CNT_W     (CNT_W)
  ) dut (
    .SYS_CLK (clk),
    .RST     (rst),
    .HALT    (halt),
    .STEP    (step),
    .CPU_CE  (cpu_ce),
    .CPU_RST (cpu_rst),
    .HB      (hb),
    .CYC_CNT (cyc_cnt),
    .STATE   (state)
  );

  // Clock
  always #5 clk = ~clk;

  // Monitor on the falling edge: pulse counts and invariants
  always @(negedge clk) begin
    if (cpu_ce === 1'b1) ce_count++;
    if (state === 2'b11) step_cycles++;
    if (cpu_ce === 1'b1 && cpu_rst === 1'b1) viol_both++;
    if (cpu_ce === 1'b1 && ce_prev === 1'b1) viol_width++;
    ce_prev = cpu_ce;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset release and free-run timing shared by scenarios 1 and 5.
  task automatic release_and_first_ce(input string tag);
    rst = 1'b0;
    tick(1);
    chk({tag, "_rst_hold"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_state_hold"}, {30'd0, state}, 32'd0);
    tick(1);
    chk({tag, "_state_run"}, {30'd0, state}, 32'd1);
    chk({tag, "_rst_drop"}, {31'd0, cpu_rst}, 32'd0);
    tick(3);
    chk({tag, "_no_early_ce"}, {31'd0, cpu_ce}, 32'd0);
    tick(1);
    chk({tag, "_first_ce"}, {31'd0, cpu_ce}, 32'd1);
    chk({tag, "_cnt1"}, {28'd0, cyc_cnt}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; step = 1'b0;

    // Scenario 1: reset, stretch, free run
    tick(5);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_hb", {31'd0, hb}, 32'd0);
    chk("rst_cnt", {28'd0, cyc_cnt}, 32'd0);
    release_and_first_ce("s1");
    chk("s1_hb_before", {31'd0, hb}, 32'd0);
    tick(1);
    chk("s1_ce_width", {31'd0, cpu_ce}, 32'd0);
    chk("s1_hb_toggle1", {31'd0, hb}, 32'd1);
    tick(3);
    chk("s1_ce2", {31'd0, cpu_ce}, 32'd1);
    chk("s1_cnt2", {28'd0, cyc_cnt}, 32'd2);
    tick(1);
    chk("s1_hb_toggle2", {31'd0, hb}, 32'd0);
    tick(3);
    chk("s1_ce3", {31'd0, cpu_ce}, 32'd1);
    chk("s1_cnt3", {28'd0, cyc_cnt}, 32'd3);
    tick(1);

    // Scenario 2: halt lands on the divider wrap, so the wrap yields no CE
    halt = 1'b1;
    tick(2);
    chk("s2_sync_delay", {30'd0, state}, 32'd1);
    tick(1);
    chk("s2_halted", {30'd0, state}, 32'd2);
    chk("s2_wrap_no_ce", {31'd0, cpu_ce}, 32'd0);
    ce_base = ce_count;
    tick(8);
    chk("s2_halt_no_ce", ce_count - ce_base, 32'd0);
    chk("s2_halt_cnt", {28'd0, cyc_cnt}, 32'd3);
    halt = 1'b0;
    tick(2);
    chk("s2_still_halt", {30'd0, state}, 32'd2);
    tick(1);
    chk("s2_rerun", {30'd0, state}, 32'd1);
    tick(3);
    chk("s2_no_early_ce", {31'd0, cpu_ce}, 32'd0);
    tick(1);
    chk("s2_ce_after_rerun", {31'd0, cpu_ce}, 32'd1);
    chk("s2_cnt4", {28'd0, cyc_cnt}, 32'd4);
    halt = 1'b1;
    tick(3);
    chk("s2_halt_again", {30'd0, state}, 32'd2);

    // Scenario 3: stepping while halted
    ce_base = ce_count; st_base = step_cycles;
    step = 1'b1;
    tick(10);
    step = 1'b0;
    tick(10);
    chk("s3_one_ce", ce_count - ce_base, 32'd1);
    chk("s3_one_step_cycle", step_cycles - st_base, 32'd1);
    chk("s3_cnt5", {28'd0, cyc_cnt}, 32'd5);
    chk("s3_hb", {31'd0, hb}, 32'd1);
    chk("s3_back_halt", {30'd0, state}, 32'd2);
    ce_base = ce_count;
    step = 1'b1;
    tick(2);
    step = 1'b0;
    tick(10);
    chk("s3_glitch_no_ce", ce_count - ce_base, 32'd0);
    chk("s3_glitch_cnt", {28'd0, cyc_cnt}, 32'd5);
    // Press while running: 5 divider CEs in the window, nothing extra
    ce_base = ce_count;
    halt = 1'b0;
    tick(3);
    chk("s3_run_entry", {30'd0, state}, 32'd1);
    step = 1'b1;
    tick(10);
    step = 1'b0;
    tick(10);
    halt = 1'b1;
    tick(3);
    chk("s3_run_halted", {30'd0, state}, 32'd2);
    chk("s3_run_ce_count", ce_count - ce_base, 32'd5);
    chk("s3_cnt10", {28'd0, cyc_cnt}, 32'd10);
    ce_base = ce_count;
    tick(20);
    chk("s3_no_queued_step", ce_count - ce_base, 32'd0);
    chk("s3_state_stays_halt", {30'd0, state}, 32'd2);

    // Scenario 4: saturation after 20 more pulses
    halt = 1'b0;
    tick(3);
    chk("s4_run_entry", {30'd0, state}, 32'd1);
    tick(80);
    chk("s4_ce20", {31'd0, cpu_ce}, 32'd1);
    chk("s4_cnt_sat", {28'd0, cyc_cnt}, 32'd15);
    chk("s4_hb_before", {31'd0, hb}, 32'd1);
    tick(1);
    chk("s4_hb_after", {31'd0, hb}, 32'd0);
    chk("s4_cnt_hold", {28'd0, cyc_cnt}, 32'd15);

    // Scenario 5a: reset mid-divide
    rst = 1'b1;
    tick(1);
    chk("s5a_state", {30'd0, state}, 32'd0);
    chk("s5a_ce", {31'd0, cpu_ce}, 32'd0);
    chk("s5a_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("s5a_cnt", {28'd0, cyc_cnt}, 32'd0);
    chk("s5a_hb", {31'd0, hb}, 32'd0);
    release_and_first_ce("s5a");

    // Scenario 5b: reset while in S_STEP
    halt = 1'b1;
    tick(4);
    chk("s5b_halted", {30'd0, state}, 32'd2);
    step = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (state === 2'b11) found = 1'b1;
    end
    chk("s5b_reached_step", {31'd0, found}, 32'd1);
    chk("s5b_step_ce", {31'd0, cpu_ce}, 32'd1);
    rst = 1'b1;
    step = 1'b0;
    halt = 1'b0;
    tick(1);
    chk("s5b_state", {30'd0, state}, 32'd0);
    chk("s5b_ce", {31'd0, cpu_ce}, 32'd0);
    chk("s5b_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("s5b_cnt", {28'd0, cyc_cnt}, 32'd0);
    chk("s5b_hb", {31'd0, hb}, 32'd0);
    tick(2);
    release_and_first_ce("s5b");
    tick(2);

    // Invariants gathered by the monitor
    chk("inv_ce_and_rst", viol_both, 32'd0);
    chk("inv_ce_width", viol_width, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $finish;
  end

endmodule
